// File: rtl/ccg_bist_harness_pkg.sv
// ---------------------------------------------------------------------------
// ccg_bist_pkg
// Shared types and constants for the CCGRCG self-test harness.
//   ccg_state_e      : harness FSM states (IDLE, RUN, DRAIN, DONE)
//   CCG_LFSR_SEED    : first pattern applied in LFSR mode
//   CCG_LFSR_TAPS    : feedback taps of x^5+x^3+1 (bits 4 and 2)
//   CCG_MISR_POLY    : MISR feedback polynomial
//   CCG_RESP_LAT_MAX : largest supported circuit response latency
// ---------------------------------------------------------------------------
package ccg_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } ccg_state_e;

    localparam logic [4:0]  CCG_LFSR_SEED    = 5'b00001;
    localparam logic [4:0]  CCG_LFSR_TAPS    = 5'b10100;
    localparam logic [15:0] CCG_MISR_POLY    = 16'h1021;
    localparam int          CCG_RESP_LAT_MAX = 3;

    // One LFSR step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [4:0] ccg_lfsr_next(input logic [4:0] cur);
        return {cur[3:0], ^(cur & CCG_LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/ccg_bist_harness_if.sv
// ---------------------------------------------------------------------------
// ccg_bist_harness_if
// Control, pattern and response signals of the self-test harness.
//   start_i, num_pat_i   : run request and pattern count
//   pat_o, resp_i        : pattern to the circuit, response back from it
//   busy_o, done_o       : run status / completion pulse
//   signature_o          : MISR contents
//   pat_idx_o            : patterns issued so far
// master: harness side; slave: the environment (circuit + controller).
// ---------------------------------------------------------------------------
interface ccg_bist_harness_if #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 5,
    parameter int CNT_W = 16,
    parameter int SIG_W = 16
);
    logic             start_i;
    logic [CNT_W-1:0] num_pat_i;
    logic [N_IN-1:0]  pat_o;
    logic [N_OUT-1:0] resp_i;
    logic             busy_o;
    logic             done_o;
    logic [SIG_W-1:0] signature_o;
    logic [CNT_W-1:0] pat_idx_o;

    modport master (
        input  start_i, num_pat_i, resp_i,
        output pat_o, busy_o, done_o, signature_o, pat_idx_o
    );

    modport slave (
        output start_i, num_pat_i, resp_i,
        input  pat_o, busy_o, done_o, signature_o, pat_idx_o
    );
endinterface

// File: rtl/ccg_bist_harness_misr.sv
// ---------------------------------------------------------------------------
// ccg_misr
// Multiple-input signature register compacting the circuit responses.
//   clk, rst : clock, asynchronous active-high reset
//   clr_i    : clear signature to zero (wins over en_i)
//   en_i     : compact data_i this cycle
//   data_i   : N_OUT-bit response, folded into the low bits
//   sig_o    : SIG_W-bit signature
// ---------------------------------------------------------------------------
module ccg_misr
    import ccg_bist_pkg::*;
#(
    parameter int N_OUT = 5,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [N_OUT-1:0] data_i,
    output logic [SIG_W-1:0] sig_o
);

    localparam logic [SIG_W-1:0] POLY = SIG_W'(CCG_MISR_POLY);

    logic [SIG_W-1:0] sig_reg;
    logic [SIG_W-1:0] sig_next;

    assign sig_next = {sig_reg[SIG_W-2:0], 1'b0}
                    ^ (sig_reg[SIG_W-1] ? POLY : '0)
                    ^ SIG_W'(data_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig_reg <= '0;
        end else if (clr_i) begin
            sig_reg <= '0;
        end else if (en_i) begin
            sig_reg <= sig_next;
        end
    end

    assign sig_o = sig_reg;

endmodule

// File: rtl/ccg_bist_harness.sv
// ---------------------------------------------------------------------------
// ccg_bist_harness
// Built-in self-test harness for the 5-in/5-out CCGRCG circuits. Drives a
// pattern sequence to the circuit, compacts the responses into a MISR.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : ccg_bist_harness_if.master (start_i, num_pat_i, pat_o,
//              resp_i, busy_o, done_o, signature_o, pat_idx_o)
// RESP_LAT (0..3) is the circuit latency from pat_o to resp_i.
// Build option CCG_BIST_EXHAUSTIVE_EN: binary up-counter from 0 replaces
// the LFSR, so the all-zero vector is also applied.
// ---------------------------------------------------------------------------
module ccg_bist_harness
    import ccg_bist_pkg::*;
#(
    parameter int N_IN     = 5,
    parameter int N_OUT    = 5,
    parameter int CNT_W    = 16,
    parameter int SIG_W    = 16,
    parameter int RESP_LAT = 0
) (
    input  logic                clk,
    input  logic                rst,
    ccg_bist_harness_if.master  bus
);

`ifdef CCG_BIST_EXHAUSTIVE_EN
    localparam logic [N_IN-1:0] PAT_SEED = '0;
`else
    localparam logic [N_IN-1:0] PAT_SEED = N_IN'(CCG_LFSR_SEED);
`endif

    ccg_state_e       state_reg;
    logic [N_IN-1:0]  pat_reg;
    logic [N_IN-1:0]  pat_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] num_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             start_fire;
    logic             run_push;
    logic             misr_en;
    logic             drain_done;

`ifdef CCG_BIST_EXHAUSTIVE_EN
    assign pat_next = pat_reg + N_IN'(1);
`else
    assign pat_next = {pat_reg[N_IN-2:0], ^(pat_reg & N_IN'(CCG_LFSR_TAPS))};
`endif

    assign cnt_next   = cnt_reg + CNT_W'(1);
    assign start_fire = bus.start_i && (state_reg == ST_IDLE || state_reg == ST_DONE);
    assign run_push   = (state_reg == ST_RUN);

    // Valid pipeline: a 1 enters for every pattern issued and reaches the
    // top bit exactly when that pattern's response is on resp_i.
    generate
        if (RESP_LAT > 0) begin : g_pipe
            logic [RESP_LAT-1:0] vld_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg <= '0;
                end else if (start_fire) begin
                    vld_reg <= '0;
                end else begin
                    vld_reg <= (vld_reg << 1) | RESP_LAT'(run_push);
                end
            end
            assign misr_en    = vld_reg[RESP_LAT-1];
            // Nothing is pushed in DRAIN, so after this shift the pipe is
            // empty once every bit below the top is clear.
            assign drain_done = ((vld_reg << 1) == '0);
        end else begin : g_nopipe
            assign misr_en    = run_push;
            assign drain_done = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            pat_reg   <= PAT_SEED;
            cnt_reg   <= '0;
            num_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (bus.start_i) begin
                        pat_reg <= PAT_SEED;
                        cnt_reg <= '0;
                        num_reg <= bus.num_pat_i;
                        if (bus.num_pat_i == '0) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end else begin
                            state_reg <= ST_RUN;
                            busy_reg  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    cnt_reg <= cnt_next;
                    if (cnt_next == num_reg) begin
                        // Last pattern stays on pat_o while responses drain.
                        if (RESP_LAT > 0) begin
                            state_reg <= ST_DRAIN;
                        end else begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end else begin
                        pat_reg <= pat_next;
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    ccg_misr #(
        .N_OUT (N_OUT),
        .SIG_W (SIG_W)
    ) u_misr (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_fire),
        .en_i   (misr_en),
        .data_i (bus.resp_i),
        .sig_o  (bus.signature_o)
    );

    assign bus.pat_o     = pat_reg;
    assign bus.busy_o    = busy_reg;
    assign bus.done_o    = done_reg;
    assign bus.pat_idx_o = cnt_reg;

endmodule

// File: tb/tb_ccg_bist_harness.sv
// ---------------------------------------------------------------------------
// tb_ccg_bist_harness
// Two harness instances: if0/u_dut0 with RESP_LAT=0 and a direct loopback
// (resp_i = pat_o), if2/u_dut2 with RESP_LAT=2 and a two-register delayed
// loopback. Expected per-cycle outputs are pushed into a scoreboard when a
// run is started and popped as the run proceeds.
// ---------------------------------------------------------------------------
module tb_ccg_bist_harness;

`ifdef CCG_BIST_EXHAUSTIVE_EN
    localparam logic [4:0] MODEL_SEED = 5'b00000;
`else
    localparam logic [4:0] MODEL_SEED = 5'b00001;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ccg_bist_harness_if if0 ();
    ccg_bist_harness_if if2 ();

    assign if0.resp_i = if0.pat_o;

    logic [4:0] dly1, dly2;
    always @(posedge clk) begin
        dly1 <= if2.pat_o;
        dly2 <= dly1;
    end
    assign if2.resp_i = dly2;

    ccg_bist_harness #(.RESP_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
    ccg_bist_harness #(.RESP_LAT(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

    bit          sel;
    logic [4:0]  obs_pat;
    logic [15:0] obs_sig;
    logic        obs_busy;
    logic        obs_done;
    logic [15:0] obs_idx;
    assign obs_pat  = sel ? if2.pat_o       : if0.pat_o;
    assign obs_sig  = sel ? if2.signature_o : if0.signature_o;
    assign obs_busy = sel ? if2.busy_o      : if0.busy_o;
    assign obs_done = sel ? if2.done_o      : if0.done_o;
    assign obs_idx  = sel ? if2.pat_idx_o   : if0.pat_idx_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [4:0]  pat;
        logic [15:0] sig;
        logic        busy;
        logic        done;
        logic [15:0] idx;
    } exp_t;
    exp_t sb[$];

    logic [4:0]  pat_log [0:79];
    logic [15:0] sig_log [0:79];

    function automatic logic [4:0] model_next(input logic [4:0] p);
`ifdef CCG_BIST_EXHAUSTIVE_EN
        return p + 5'd1;
`else
        return {p[3:0], p[4] ^ p[2]};
`endif
    endfunction

    function automatic logic [15:0] model_sig(input logic [15:0] s, input logic [4:0] r);
        logic [15:0] t;
        t = {s[14:0], 1'b0};
        if (s[15]) t = t ^ 16'h1021;
        return t ^ {11'b0, r};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_start(input int which, input logic v, input logic [15:0] n);
        if (which == 0) begin
            if0.start_i   = v;
            if0.num_pat_i = n;
        end else begin
            if2.start_i   = v;
            if2.num_pat_i = n;
        end
    endtask

    // Starts an n-pattern run on instance `which` (latency lat) in the
    // current cycle, optionally pulsing start_i again in cycle `poke`, and
    // checks every cycle up to one past the done pulse.
    task automatic run(input int which, input int n, input int lat, input int poke);
        logic [4:0]  p [0:63];
        logic [15:0] s [0:63];
        exp_t        e;
        int          done_c;
        int          m;
        p[0] = MODEL_SEED;
        p[1] = MODEL_SEED;
        for (int k = 2; k <= n; k++) p[k] = model_next(p[k-1]);
        s[0] = 16'h0000;
        for (int k = 1; k <= n; k++) s[k] = model_sig(s[k-1], p[k]);
        done_c = (n == 0) ? 1 : n + lat + 1;
        for (int c = 1; c <= done_c + 1; c++) begin
            e.pat  = (c <= n) ? p[c] : p[n];
            m      = c - 1 - lat;
            if (m < 0) m = 0;
            if (m > n) m = n;
            e.sig  = s[m];
            e.busy = (n > 0) && (c <= n + lat);
            e.done = (c == done_c);
            e.idx  = (c <= n) ? 16'(c - 1) : 16'(n);
            sb.push_back(e);
        end

        sel = (which != 0);
        set_start(which, 1'b1, 16'(n));
        tick();
        for (int c = 1; c <= done_c + 1; c++) begin
            e = sb.pop_front();
            pat_log[c] = obs_pat;
            sig_log[c] = obs_sig;
            total++;
            if (obs_pat !== e.pat) begin
                bad++;
                $display("FAIL pat n=%0d cyc=%0d got=%h want=%h", n, c, obs_pat, e.pat);
            end
            total++;
            if (obs_sig !== e.sig) begin
                bad++;
                $display("FAIL sig n=%0d cyc=%0d got=%h want=%h", n, c, obs_sig, e.sig);
            end
            total++;
            if (obs_busy !== e.busy) begin
                bad++;
                $display("FAIL busy n=%0d cyc=%0d got=%b want=%b", n, c, obs_busy, e.busy);
            end
            total++;
            if (obs_done !== e.done) begin
                bad++;
                $display("FAIL done n=%0d cyc=%0d got=%b want=%b", n, c, obs_done, e.done);
            end
            total++;
            if (obs_idx !== e.idx) begin
                bad++;
                $display("FAIL idx n=%0d cyc=%0d got=%0d want=%0d", n, c, obs_idx, e.idx);
            end
            $display("run dut=%0d n=%0d cyc=%0d pat=%h sig=%h busy=%b done=%b idx=%0d",
                     which, n, c, obs_pat, obs_sig, obs_busy, obs_done, obs_idx);
            // start_i pulses and num_pat_i changes here must not disturb the run
            set_start(which, (c == poke), 16'($urandom_range(1, 40)));
            tick();
        end
        set_start(which, 1'b0, 16'h0000);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_start(0, 1'b0, 16'h0000);
        set_start(2, 1'b0, 16'h0000);
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (if0.pat_o !== MODEL_SEED || if2.pat_o !== MODEL_SEED) begin
                bad++;
                $display("FAIL reset_pat got=%h/%h want=%h", if0.pat_o, if2.pat_o, MODEL_SEED);
            end
            total++;
            if (if0.signature_o !== 16'h0000 || if2.signature_o !== 16'h0000) begin
                bad++;
                $display("FAIL reset_sig got=%h/%h want=0000", if0.signature_o, if2.signature_o);
            end
            total++;
            if ({if0.busy_o, if0.done_o, if2.busy_o, if2.done_o} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_flags got=%b%b%b%b want=0000",
                         if0.busy_o, if0.done_o, if2.busy_o, if2.done_o);
            end
            total++;
            if (if0.pat_idx_o !== 16'd0 || if2.pat_idx_o !== 16'd0) begin
                bad++;
                $display("FAIL reset_idx got=%0d/%0d want=0", if0.pat_idx_o, if2.pat_idx_o);
            end
            $display("reset idle cyc=%0d pat=%h sig=%h", i, if0.pat_o, if0.signature_o);
        end
    endtask

    task automatic test_loopback_lat0();
        logic [4:0]  gold_pat [1:6];
        logic [15:0] gold_sig [2:4];
`ifdef CCG_BIST_EXHAUSTIVE_EN
        gold_pat = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05};
        gold_sig = '{16'h0000, 16'h0001, 16'h0000};
`else
        gold_pat = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12, 5'h05};
        gold_sig = '{16'h0001, 16'h0000, 16'h0004};
`endif
        run(0, 6, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (pat_log[k] !== gold_pat[k]) begin
                bad++;
                $display("FAIL golden_pat k=%0d got=%h want=%h", k, pat_log[k], gold_pat[k]);
            end
        end
        for (int k = 2; k <= 4; k++) begin
            total++;
            if (sig_log[k] !== gold_sig[k]) begin
                bad++;
                $display("FAIL golden_sig cyc=%0d got=%h want=%h", k, sig_log[k], gold_sig[k]);
            end
        end
    endtask

    task automatic test_wrap32();
        logic [4:0] want32;
`ifdef CCG_BIST_EXHAUSTIVE_EN
        want32 = 5'd31;
`else
        want32 = 5'h01;
`endif
        run(0, 32, 0, 0);
        total++;
        if (pat_log[32] !== want32) begin
            bad++;
            $display("FAIL wrap32 got=%h want=%h", pat_log[32], want32);
        end
    endtask

    task automatic test_lat2();
        logic [15:0] want;
`ifdef CCG_BIST_EXHAUSTIVE_EN
        want = 16'h0000;
`else
        want = 16'h0004;
`endif
        run(2, 3, 2, 0);
        total++;
        if (sig_log[6] !== want) begin
            bad++;
            $display("FAIL lat2_final got=%h want=%h", sig_log[6], want);
        end
    endtask

    task automatic test_zero_and_ignore();
        run(0, 0, 0, 0);
        run(0, 10, 0, 4);
    endtask

    task automatic test_rst_midrun();
        sel = 1'b0;
        set_start(0, 1'b1, 16'd10);
        tick();
        set_start(0, 1'b0, 16'd3);
        tick();
        tick();
        tick();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (if0.pat_o !== MODEL_SEED || if0.signature_o !== 16'h0000 ||
                if0.pat_idx_o !== 16'd0 || if0.busy_o !== 1'b0 || if0.done_o !== 1'b0) begin
                bad++;
                $display("FAIL rst_mid i=%0d got pat=%h sig=%h idx=%0d busy=%b done=%b want reset values",
                         i, if0.pat_o, if0.signature_o, if0.pat_idx_o, if0.busy_o, if0.done_o);
            end
            $display("rst_mid i=%0d pat=%h sig=%h busy=%b done=%b",
                     i, if0.pat_o, if0.signature_o, if0.busy_o, if0.done_o);
            tick();
        end
        rst = 1'b0;
        tick();
        total++;
        if (if0.busy_o !== 1'b0 || if0.done_o !== 1'b0) begin
            bad++;
            $display("FAIL rst_release got busy=%b done=%b want 0 0", if0.busy_o, if0.done_o);
        end
        run(0, 10, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        sel = 1'b0;
        set_start(0, 1'b0, 16'h0000);
        set_start(2, 1'b0, 16'h0000);
        test_reset();
        test_loopback_lat0();
        test_wrap32();
        test_lat2();
        test_zero_and_ignore();
        test_rst_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
